// File: rtl/ir_nec_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ir_nec_tx
//  Purpose  : NEC-format IR remote transmitter. Sends a lead mark/space,
//             the 32-bit word {~cmd, cmd, ~addr, addr} LSB first using
//             pulse-distance coding, and a stop mark. Output is the
//             demodulated waveform: idle/space = 1, mark = 0.
//  Options  : IR_TX_REPEAT_EN - while send_hold_i is high after a frame,
//             emit NEC repeat codes every FRAME_UNITS units.
//  Revision : 1.0  initial release
// ============================================================================
module ir_nec_tx #(
    parameter int UNIT_CYC    = 28125,
    parameter int FRAME_UNITS = 192
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] cmd_i,
    input  logic       send_hold_i,
    output logic       irda_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [5:0] bit_idx_o
);

    // Per-state counter only ever needs to hold the longest state (16 units).
    localparam int CW = $clog2(16 * UNIT_CYC);

    localparam logic [CW-1:0] c_CYC_LEAD_MARK  = CW'(16 * UNIT_CYC - 1);
    localparam logic [CW-1:0] c_CYC_LEAD_SPACE = CW'(8 * UNIT_CYC - 1);
    localparam logic [CW-1:0] c_CYC_ONE_SPACE  = CW'(3 * UNIT_CYC - 1);
    localparam logic [CW-1:0] c_CYC_UNIT       = CW'(UNIT_CYC - 1);

`ifdef IR_TX_REPEAT_EN
    // Frame-period counter spans a whole repetition period.
    localparam int PW = $clog2(FRAME_UNITS * UNIT_CYC);
    localparam logic [PW-1:0] c_CYC_FRAME     = PW'(FRAME_UNITS * UNIT_CYC - 1);
    localparam logic [CW-1:0] c_CYC_REP_SPACE = CW'(4 * UNIT_CYC - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LEAD_MARK  = 4'd1,
        S_LEAD_SPACE = 4'd2,
        S_BIT_MARK   = 4'd3,
        S_BIT_SPACE  = 4'd4,
        S_STOP_MARK  = 4'd5
`ifdef IR_TX_REPEAT_EN
        ,
        S_GAP        = 4'd6,
        S_REP_MARK   = 4'd7,
        S_REP_SPACE  = 4'd8,
        S_REP_STOP   = 4'd9
`endif
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [31:0]     shift_q,   shift_d;
    logic [5:0]      bit_idx_q, bit_idx_d;
    logic            out_q,     out_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
`ifdef IR_TX_REPEAT_EN
    logic [PW-1:0]   per_q,     per_d;
`else
    logic            w_unused_hold;
    assign w_unused_hold = send_hold_i;
`endif

    // Next-state, timer reload and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef IR_TX_REPEAT_EN
        per_d     = (per_q == '0) ? '0 : per_q - 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_LEAD_MARK;
                    cnt_d     = c_CYC_LEAD_MARK;
                    shift_d   = {~cmd_i, cmd_i, ~addr_i, addr_i};
                    bit_idx_d = 6'd0;
                    out_d     = 1'b0;
                    busy_d    = 1'b1;
`ifdef IR_TX_REPEAT_EN
                    per_d     = c_CYC_FRAME;
`endif
                end
            end
            S_LEAD_MARK: begin
                if (cnt_q == '0) begin
                    state_d = S_LEAD_SPACE;
                    cnt_d   = c_CYC_LEAD_SPACE;
                    out_d   = 1'b1;
                end
            end
            S_LEAD_SPACE: begin
                if (cnt_q == '0) begin
                    state_d = S_BIT_MARK;
                    cnt_d   = c_CYC_UNIT;
                    out_d   = 1'b0;
                end
            end
            S_BIT_MARK: begin
                if (cnt_q == '0) begin
                    state_d = S_BIT_SPACE;
                    cnt_d   = shift_q[0] ? c_CYC_ONE_SPACE : c_CYC_UNIT;
                    out_d   = 1'b1;
                end
            end
            S_BIT_SPACE: begin
                if (cnt_q == '0) begin
                    cnt_d = c_CYC_UNIT;
                    out_d = 1'b0;
                    if (bit_idx_q == 6'd31) begin
                        state_d   = S_STOP_MARK;
                        bit_idx_d = 6'd0;
                    end else begin
                        state_d   = S_BIT_MARK;
                        bit_idx_d = bit_idx_q + 6'd1;
                        shift_d   = {1'b0, shift_q[31:1]};
                    end
                end
            end
            S_STOP_MARK: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    out_d  = 1'b1;
`ifdef IR_TX_REPEAT_EN
                    if (send_hold_i) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
`endif
                end
            end
`ifdef IR_TX_REPEAT_EN
            S_GAP: begin
                if (!send_hold_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (per_q == '0) begin
                    state_d = S_REP_MARK;
                    cnt_d   = c_CYC_LEAD_MARK;
                    out_d   = 1'b0;
                    per_d   = c_CYC_FRAME;
                end
            end
            S_REP_MARK: begin
                if (cnt_q == '0) begin
                    state_d = S_REP_SPACE;
                    cnt_d   = c_CYC_REP_SPACE;
                    out_d   = 1'b1;
                end
            end
            S_REP_SPACE: begin
                if (cnt_q == '0) begin
                    state_d = S_REP_STOP;
                    cnt_d   = c_CYC_UNIT;
                    out_d   = 1'b0;
                end
            end
            S_REP_STOP: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    out_d  = 1'b1;
                    if (send_hold_i) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= 6'd0;
            out_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef IR_TX_REPEAT_EN
            per_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef IR_TX_REPEAT_EN
            per_q     <= per_d;
`endif
        end
    end

    assign irda_out_o = out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign bit_idx_o  = bit_idx_q;

endmodule
`default_nettype wire
